// File: rtl/issue_select_queue_if.sv
// Rename/wakeup/issue handshake bundle for issue_select_queue.
// master = rename + writeback + consumer side, slave = the queue itself.
interface issue_select_queue_if #(
    parameter int unsigned DATA_W   = 137,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned NUM_WAKE = 2
);
    logic                          push_valid;
    logic                          push_ready;
    logic [DATA_W-1:0]             push_data;
    logic [TAG_W-1:0]              push_src1_tag;
    logic [TAG_W-1:0]              push_src2_tag;
    logic                          push_src1_rdy;
    logic                          push_src2_rdy;
    logic [NUM_WAKE-1:0]           wake_valid;
    logic [NUM_WAKE*TAG_W-1:0]     wake_tag;
    logic                          pop_valid;
    logic                          pop_ready;
    logic [DATA_W-1:0]             pop_data;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output push_valid, push_data, push_src1_tag, push_src2_tag, push_src1_rdy, push_src2_rdy,
        output wake_valid, wake_tag, pop_ready,
        input  push_ready, pop_valid, pop_data, count
    );

    modport slave (
        input  push_valid, push_data, push_src1_tag, push_src2_tag, push_src1_rdy, push_src2_rdy,
        input  wake_valid, wake_tag, pop_ready,
        output push_ready, pop_valid, pop_data, count
    );
endinterface

// File: rtl/issue_select_queue.sv
// Collapsing, age-ordered wakeup/select issue queue; slot 0 holds the oldest entry.
// Define ISS_PUSH_WAKE_EN to also wake the entry being pushed from same-cycle broadcasts.
module issue_select_queue #(
    parameter int unsigned DATA_W   = 137,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned NUM_WAKE = 2,
    parameter int unsigned IN_ORDER = 0
) (
    input logic                 CLK,
    input logic                 RESET,
    input logic                 FREEZE,
    input logic                 FLUSH,
    issue_select_queue_if.slave q
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  validQ, validD, src1RdyQ, src1RdyD, src2RdyQ, src2RdyD;
    logic [TAG_W-1:0]  src1TagQ [DEPTH];
    logic [TAG_W-1:0]  src1TagD [DEPTH];
    logic [TAG_W-1:0]  src2TagQ [DEPTH];
    logic [TAG_W-1:0]  src2TagD [DEPTH];
    logic [DATA_W-1:0] dataQ    [DEPTH];
    logic [DATA_W-1:0] dataD    [DEPTH];
    logic [CNT_W-1:0]  countQ, countD, pushIdx;

    // One extra always-empty slot so the shift-down source index never leaves the array.
    logic [DEPTH:0]    validExt, rdy1Ext, rdy2Ext;
    logic [TAG_W-1:0]  tag1Ext [DEPTH+1];
    logic [TAG_W-1:0]  tag2Ext [DEPTH+1];
    logic [DATA_W-1:0] dataExt [DEPTH+1];

    logic [DEPTH-1:0]  eligible;
    logic [IDX_W-1:0]  selIdx;
    logic              popValid, popFire, pushReady, pushFire, pushRdy1, pushRdy2;

    function automatic logic tagWoken(input logic [TAG_W-1:0] tag,
                                      input logic [NUM_WAKE-1:0] wv,
                                      input logic [NUM_WAKE*TAG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKE; k++) begin
            if (wv[k] && (wt[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            validExt[i] = validQ[i];
            rdy1Ext[i]  = src1RdyQ[i] | tagWoken(src1TagQ[i], q.wake_valid, q.wake_tag);
            rdy2Ext[i]  = src2RdyQ[i] | tagWoken(src2TagQ[i], q.wake_valid, q.wake_tag);
            tag1Ext[i]  = src1TagQ[i];
            tag2Ext[i]  = src2TagQ[i];
            dataExt[i]  = dataQ[i];
        end
        validExt[DEPTH] = 1'b0;
        rdy1Ext[DEPTH]  = 1'b0;
        rdy2Ext[DEPTH]  = 1'b0;
        tag1Ext[DEPTH]  = '0;
        tag2Ext[DEPTH]  = '0;
        dataExt[DEPTH]  = '0;
    end

    // Select works on registered rdy bits; a wakeup becomes visible the following cycle.
    always_comb begin
        selIdx   = '0;
        popValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = validQ[i] & src1RdyQ[i] & src2RdyQ[i] & ((IN_ORDER == 0) || (i == 0));
            if (eligible[i] && !popValid) begin
                selIdx   = IDX_W'(i);
                popValid = 1'b1;
            end
        end
    end

    assign pushReady = !FREEZE && !FLUSH && (countQ < CNT_W'(DEPTH));
    assign popFire   = popValid && q.pop_ready && !FREEZE && !FLUSH;
    assign pushFire  = q.push_valid && pushReady;
    assign pushIdx   = popFire ? countQ - CNT_W'(1) : countQ;

`ifdef ISS_PUSH_WAKE_EN
    assign pushRdy1 = q.push_src1_rdy | tagWoken(q.push_src1_tag, q.wake_valid, q.wake_tag);
    assign pushRdy2 = q.push_src2_rdy | tagWoken(q.push_src2_tag, q.wake_valid, q.wake_tag);
`else
    assign pushRdy1 = q.push_src1_rdy;
    assign pushRdy2 = q.push_src2_rdy;
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (popFire && (i >= int'(selIdx))) begin
                validD[i]   = validExt[i+1];
                src1RdyD[i] = rdy1Ext[i+1];
                src2RdyD[i] = rdy2Ext[i+1];
                src1TagD[i] = tag1Ext[i+1];
                src2TagD[i] = tag2Ext[i+1];
                dataD[i]    = dataExt[i+1];
            end else begin
                validD[i]   = validExt[i];
                src1RdyD[i] = rdy1Ext[i];
                src2RdyD[i] = rdy2Ext[i];
                src1TagD[i] = tag1Ext[i];
                src2TagD[i] = tag2Ext[i];
                dataD[i]    = dataExt[i];
            end
            if (pushFire && (CNT_W'(i) == pushIdx)) begin
                validD[i]   = 1'b1;
                src1RdyD[i] = pushRdy1;
                src2RdyD[i] = pushRdy2;
                src1TagD[i] = q.push_src1_tag;
                src2TagD[i] = q.push_src2_tag;
                dataD[i]    = q.push_data;
            end
        end
        countD = countQ + CNT_W'(pushFire) - CNT_W'(popFire);
        if (FLUSH) begin
            validD = '0;
            countD = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            validQ   <= '0;
            src1RdyQ <= '0;
            src2RdyQ <= '0;
            countQ   <= '0;
        end else begin
            validQ   <= validD;
            src1RdyQ <= src1RdyD;
            src2RdyQ <= src2RdyD;
            countQ   <= countD;
        end
    end

    // Tags and payload are qualified by validQ, so they need no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            src1TagQ[i] <= src1TagD[i];
            src2TagQ[i] <= src2TagD[i];
            dataQ[i]    <= dataD[i];
        end
    end

    assign q.push_ready = pushReady;
    assign q.pop_valid  = popValid;
    assign q.pop_data   = popValid ? dataQ[selIdx] : '0;
    assign q.count      = countQ;
endmodule

// File: tb/tb_issue_select_queue.sv
// Scoreboard bench for issue_select_queue: one out-of-order instance and one IN_ORDER=1 instance.
module tb_issue_select_queue;
    localparam int unsigned DATA_W   = 137;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned NUM_WAKE = 2;

    typedef logic [DATA_W-1:0] word_t;

    logic CLK    = 1'b0;
    logic RESET  = 1'b0;
    logic FREEZE = 1'b0;
    logic FLUSH  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    word_t expQA[$];
    word_t expQB[$];

    always #5 CLK = ~CLK;

    issue_select_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) ifA ();
    issue_select_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) ifB ();

    issue_select_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE), .IN_ORDER(0)
    ) dutA (.CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .q(ifA));

    issue_select_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE), .IN_ORDER(1)
    ) dutB (.CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .q(ifB));

    task automatic checkVal(input string tag, input word_t got, input word_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setPush(input bit sel, input bit v, input word_t d, input logic [TAG_W-1:0] t1,
                           input logic r1, input logic [TAG_W-1:0] t2, input logic r2);
        if (!sel) begin
            ifA.push_valid = v; ifA.push_data = d;
            ifA.push_src1_tag = t1; ifA.push_src1_rdy = r1;
            ifA.push_src2_tag = t2; ifA.push_src2_rdy = r2;
        end else begin
            ifB.push_valid = v; ifB.push_data = d;
            ifB.push_src1_tag = t1; ifB.push_src1_rdy = r1;
            ifB.push_src2_tag = t2; ifB.push_src2_rdy = r2;
        end
    endtask

    task automatic pushOne(input bit sel, input word_t d, input logic [TAG_W-1:0] t1,
                           input logic r1, input logic [TAG_W-1:0] t2, input logic r2);
        setPush(sel, 1'b1, d, t1, r1, t2, r2);
        tick();
        setPush(sel, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic setWake(input bit sel, input int port, input logic [TAG_W-1:0] tag);
        logic [NUM_WAKE-1:0]       wv;
        logic [NUM_WAKE*TAG_W-1:0] wt;
        wv = '0;
        wt = '0;
        wv[port] = 1'b1;
        wt[port*TAG_W +: TAG_W] = tag;
        if (!sel) begin ifA.wake_valid = wv; ifA.wake_tag = wt; end
        else      begin ifB.wake_valid = wv; ifB.wake_tag = wt; end
    endtask

    task automatic wakeOne(input bit sel, input int port, input logic [TAG_W-1:0] tag);
        setWake(sel, port, tag);
        tick();
        ifA.wake_valid = '0;
        ifB.wake_valid = '0;
    endtask

    // Scoreboard pop: compare the presented entry with the oldest expectation, then accept it.
    task automatic popOne(input bit sel, input string tag);
        word_t e;
        int    n;
        n = sel ? expQB.size() : expQA.size();
        if (n == 0) begin
            checkVal({tag, " scoreboard depth"}, word_t'(n), word_t'(1));
        end else begin
            e = sel ? expQB.pop_front() : expQA.pop_front();
            if (!sel) begin
                checkVal({tag, " pop_valid"}, word_t'(ifA.pop_valid), word_t'(1));
                checkVal({tag, " pop_data"}, ifA.pop_data, e);
                ifA.pop_ready = 1'b1;
                tick();
                ifA.pop_ready = 1'b0;
            end else begin
                checkVal({tag, " pop_valid"}, word_t'(ifB.pop_valid), word_t'(1));
                checkVal({tag, " pop_data"}, ifB.pop_data, e);
                ifB.pop_ready = 1'b1;
                tick();
                ifB.pop_ready = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifA.wake_valid = '0; ifA.wake_tag = '0; ifA.pop_ready = 1'b0;
        ifB.wake_valid = '0; ifB.wake_tag = '0; ifB.pop_ready = 1'b0;
        setPush(1'b0, 1'b1, word_t'(77), '0, 1'b1, '0, 1'b1);
        setPush(1'b1, 1'b1, word_t'(78), '0, 1'b1, '0, 1'b1);

        // Reset held two cycles while rename is pushing.
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        setPush(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        setPush(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        checkVal("reset count", word_t'(ifA.count), word_t'(0));
        checkVal("reset pop_valid", word_t'(ifA.pop_valid), word_t'(0));
        checkVal("reset pop_data", ifA.pop_data, word_t'(0));
        checkVal("reset push_ready", word_t'(ifA.push_ready), word_t'(1));
        checkVal("reset countB", word_t'(ifB.count), word_t'(0));

        // Fill to full with nothing ready, then try a 17th push.
        for (int i = 0; i < 16; i++) begin
            setPush(1'b0, 1'b1, word_t'(100 + i), 6'd1, 1'b0, 6'd1, 1'b0);
            tick();
        end
        checkVal("full count", word_t'(ifA.count), word_t'(16));
        checkVal("full push_ready", word_t'(ifA.push_ready), word_t'(0));
        checkVal("full pop_valid", word_t'(ifA.pop_valid), word_t'(0));
        setPush(1'b0, 1'b1, word_t'(200), 6'd1, 1'b0, 6'd1, 1'b0);
        tick();
        setPush(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        checkVal("overfull count", word_t'(ifA.count), word_t'(16));
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        checkVal("flush count", word_t'(ifA.count), word_t'(0));
        checkVal("flush pop_valid", word_t'(ifA.pop_valid), word_t'(0));

        // Wake and age order.
        pushOne(1'b0, word_t'('hA0), 6'd5, 1'b0, 6'd0, 1'b1);
        pushOne(1'b0, word_t'('hA1), 6'd9, 1'b0, 6'd0, 1'b1);
        pushOne(1'b0, word_t'('hA2), 6'd5, 1'b0, 6'd0, 1'b1);
        checkVal("age count", word_t'(ifA.count), word_t'(3));
        checkVal("age idle", word_t'(ifA.pop_valid), word_t'(0));
        expQA.push_back(word_t'('hA0));
        expQA.push_back(word_t'('hA2));
        wakeOne(1'b0, 1, 6'd5);
        popOne(1'b0, "age oldest");
        popOne(1'b0, "age collapsed");
        checkVal("age tag9 waits", word_t'(ifA.pop_valid), word_t'(0));
        checkVal("age tag9 count", word_t'(ifA.count), word_t'(1));
        expQA.push_back(word_t'('hA1));
        wakeOne(1'b0, 0, 6'd9);
        popOne(1'b0, "age tag9");

        // Simultaneous push and pop at count=4; new entry must land youngest.
        pushOne(1'b0, word_t'('hB0), 6'd0, 1'b1, 6'd0, 1'b1);
        pushOne(1'b0, word_t'('hB1), 6'd20, 1'b0, 6'd0, 1'b1);
        pushOne(1'b0, word_t'('hB2), 6'd0, 1'b1, 6'd20, 1'b0);
        pushOne(1'b0, word_t'('hB3), 6'd20, 1'b0, 6'd20, 1'b0);
        checkVal("pp count before", word_t'(ifA.count), word_t'(4));
        expQA.push_back(word_t'('hB0));
        setPush(1'b0, 1'b1, word_t'('hB4), 6'd0, 1'b1, 6'd0, 1'b1);
        popOne(1'b0, "pp pop");
        setPush(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        checkVal("pp count after", word_t'(ifA.count), word_t'(4));
        expQA.push_back(word_t'('hB1));
        expQA.push_back(word_t'('hB2));
        expQA.push_back(word_t'('hB3));
        expQA.push_back(word_t'('hB4));
        wakeOne(1'b0, 0, 6'd20);
        popOne(1'b0, "burst 0");
        popOne(1'b0, "burst 1");
        popOne(1'b0, "burst 2");
        popOne(1'b0, "burst 3");
        checkVal("burst count", word_t'(ifA.count), word_t'(0));

        // FLUSH during a push.
        pushOne(1'b0, word_t'('hC0), 6'd30, 1'b0, 6'd0, 1'b1);
        setPush(1'b0, 1'b1, word_t'('hC1), 6'd0, 1'b1, 6'd0, 1'b1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        setPush(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        checkVal("flush push count", word_t'(ifA.count), word_t'(0));
        checkVal("flush push pop_valid", word_t'(ifA.pop_valid), word_t'(0));

        // FREEZE blocks push/pop but still captures wakeups.
        pushOne(1'b0, word_t'('hE0), 6'd11, 1'b0, 6'd0, 1'b1);
        FREEZE = 1'b1;
        #1;
        checkVal("freeze push_ready", word_t'(ifA.push_ready), word_t'(0));
        wakeOne(1'b0, 1, 6'd11);
        checkVal("freeze wake", word_t'(ifA.pop_valid), word_t'(1));
        ifA.pop_ready = 1'b1;
        tick();
        ifA.pop_ready = 1'b0;
        checkVal("freeze no pop", word_t'(ifA.count), word_t'(1));
        FREEZE = 1'b0;
        expQA.push_back(word_t'('hE0));
        popOne(1'b0, "after freeze");

        // Same-cycle push and wake on tag 7.
        setPush(1'b0, 1'b1, word_t'('hD0), 6'd7, 1'b0, 6'd0, 1'b1);
        setWake(1'b0, 0, 6'd7);
        tick();
        setPush(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        ifA.wake_valid = '0;
`ifdef ISS_PUSH_WAKE_EN
        expQA.push_back(word_t'('hD0));
        popOne(1'b0, "push+wake");
`else
        checkVal("push+wake lost", word_t'(ifA.pop_valid), word_t'(0));
        tick();
        checkVal("push+wake still", word_t'(ifA.pop_valid), word_t'(0));
        expQA.push_back(word_t'('hD0));
        wakeOne(1'b0, 0, 6'd7);
        popOne(1'b0, "late wake");
`endif

        // IN_ORDER: ready slot 1 must wait behind a blocked head.
        pushOne(1'b1, word_t'('hF0), 6'd3, 1'b0, 6'd0, 1'b1);
        pushOne(1'b1, word_t'('hF1), 6'd0, 1'b1, 6'd0, 1'b1);
        ifB.pop_ready = 1'b1;
        checkVal("inorder blocked0", word_t'(ifB.pop_valid), word_t'(0));
        tick();
        checkVal("inorder blocked1", word_t'(ifB.pop_valid), word_t'(0));
        checkVal("inorder count", word_t'(ifB.count), word_t'(2));
        expQB.push_back(word_t'('hF0));
        expQB.push_back(word_t'('hF1));
        wakeOne(1'b1, 0, 6'd3);
        popOne(1'b1, "inorder head");
        popOne(1'b1, "inorder next");
        checkVal("inorder empty", word_t'(ifB.count), word_t'(0));

        checkVal("scoreboard A drained", word_t'(expQA.size()), word_t'(0));
        checkVal("scoreboard B drained", word_t'(expQB.size()), word_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
